// File: rtl/fusion_shift_ctrl.sv
// -----------------------------------------------------------------------------
// fusion_shift_ctrl
// Sequencing controller for the two-channel weighted fusion datapath. Turns
// debounced operator inc/dec keys into a target horizontal offset of channel 2
// and realises it by issuing one move pulse per line during horizontal
// blanking. The datapath can only add shift, so a decrease resets the datapath
// and re-applies the whole target from zero, starting at the next frame.
//
// Optional feature (macro FUSION_SHIFT_WRAP_EN):
//   defined   : inc at MAX_SHIFT wraps the target to 0, dec at 0 wraps it to
//               MAX_SHIFT (a wrap to 0 then takes the normal resync path).
//   undefined : the target saturates at 0 and MAX_SHIFT.
//
// Ports:
//   clk_ch2       in   channel-2 pixel clock, all logic in this domain
//   rst_n         in   asynchronous active-low reset
//   key_inc       in   raw asynchronous key, request offset +1
//   key_dec       in   raw asynchronous key, request offset -1
//   ch2_vsync     in   channel-2 frame sync, active-high
//   ch2_valid     in   channel-2 active-pixel qualifier
//   move_r        out  one-cycle pulse, datapath inserts one ch2 pixel
//   fusion_rst_n  out  active-low reset to the fusion datapath
//   shift_target  out  debounced requested offset
//   shift_applied out  offset currently realised in the datapath
//   busy          out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module fusion_shift_ctrl #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000,
    parameter logic [7:0]  MAX_SHIFT  = 8'd255,
    parameter logic [7:0]  RST_CYCLES = 8'd16,
    parameter int unsigned SW         = 8
) (
    input  logic          clk_ch2,
    input  logic          rst_n,
    input  logic          key_inc,
    input  logic          key_dec,
    input  logic          ch2_vsync,
    input  logic          ch2_valid,
    output logic          move_r,
    output logic          fusion_rst_n,
    output logic [SW-1:0] shift_target,
    output logic [SW-1:0] shift_applied,
    output logic          busy
);

    localparam int unsigned DW = 20;
    localparam int unsigned RW = 8;
    localparam logic [SW-1:0] MAX_S = SW'(MAX_SHIFT);

    typedef enum logic [2:0] {
        FRST      = 3'd0,
        IDLE      = 3'd1,
        WAIT_LINE = 3'd2,
        PULSE     = 3'd3,
        CHECK     = 3'd4
    } state_t;

    // Key synchronisers and debouncers; bit 0 = inc, bit 1 = dec
    logic [1:0]    key_raw;
    logic [1:0]    key_s1;
    logic [1:0]    key_s2;
    logic [1:0]    deb_lvl;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    deb_rise;

    assign key_raw = {key_dec, key_inc};

    always_ff @(posedge clk_ch2 or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
        end
    end

    // Any sample equal to the accepted level reloads the counter, so only an
    // uninterrupted run of DEB_CYCLES differing samples flips the level.
    always_ff @(posedge clk_ch2 or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl <= '0;
            for (int k = 0; k < 2; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (key_s2[k] == deb_lvl[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_CYCLES - DW'(1)) begin
                    deb_lvl[k] <= key_s2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        deb_rise = '0;
        for (int k = 0; k < 2; k++) begin
            deb_rise[k] = key_s2[k] && !deb_lvl[k] && (deb_cnt[k] == DEB_CYCLES - DW'(1));
        end
    end

    // Target update; simultaneous inc and dec cancel out
    logic [SW-1:0] target_nxt;

    always_comb begin
        target_nxt = shift_target;
        if (deb_rise == 2'b01) begin
            if (shift_target >= MAX_S) begin
`ifdef FUSION_SHIFT_WRAP_EN
                target_nxt = '0;
`else
                target_nxt = MAX_S;
`endif
            end else begin
                target_nxt = shift_target + SW'(1);
            end
        end else if (deb_rise == 2'b10) begin
            if (shift_target == '0) begin
`ifdef FUSION_SHIFT_WRAP_EN
                target_nxt = MAX_S;
`else
                target_nxt = '0;
`endif
            end else begin
                target_nxt = shift_target - SW'(1);
            end
        end
    end

    always_ff @(posedge clk_ch2 or negedge rst_n) begin
        if (!rst_n) begin
            shift_target <= '0;
        end else begin
            shift_target <= target_nxt;
        end
    end

    // Frame/line timing edges from once-registered syncs
    logic vs_d1, vs_d2, vl_d1, vl_d2;
    logic vs_rise, line_end;

    always_ff @(posedge clk_ch2 or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1 <= 1'b0;
            vs_d2 <= 1'b0;
            vl_d1 <= 1'b0;
            vl_d2 <= 1'b0;
        end else begin
            vs_d1 <= ch2_vsync;
            vs_d2 <= vs_d1;
            vl_d1 <= ch2_valid;
            vl_d2 <= vl_d1;
        end
    end

    assign vs_rise  = vs_d1 && !vs_d2;
    assign line_end = !vl_d1 && vl_d2;

    // Sequencer state register
    state_t        state, state_next;
    logic [RW-1:0] rst_cnt;

    always_ff @(posedge clk_ch2 or negedge rst_n) begin
        if (!rst_n) begin
            state <= FRST;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            FRST: begin
                if (rst_cnt == RST_CYCLES - RW'(1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (vs_rise) begin
                    if (shift_target < shift_applied) begin
                        state_next = FRST;
                    end else if (shift_target > shift_applied) begin
                        state_next = WAIT_LINE;
                    end
                end
            end
            WAIT_LINE: begin
                if (line_end) begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (shift_target > shift_applied) begin
                    state_next = WAIT_LINE;
                end else if (shift_target < shift_applied) begin
                    state_next = FRST;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = FRST;
            end
        endcase
    end

    // Output decode, computed from the next state so outputs stay registered
    logic          move_nxt;
    logic          frst_n_nxt;
    logic          busy_nxt;
    logic [SW-1:0] applied_nxt;
    logic [RW-1:0] rst_cnt_nxt;

    always_comb begin
        move_nxt    = 1'b0;
        frst_n_nxt  = 1'b1;
        busy_nxt    = 1'b1;
        applied_nxt = shift_applied;
        rst_cnt_nxt = '0;
        if (state_next == FRST) begin
            frst_n_nxt  = 1'b0;
            applied_nxt = '0;
            if (state == FRST) begin
                rst_cnt_nxt = rst_cnt + RW'(1);
            end
        end
        if (state_next == PULSE) begin
            move_nxt = 1'b1;
            if (shift_applied < MAX_S) begin
                applied_nxt = shift_applied + SW'(1);
            end
        end
        if (state_next == IDLE) begin
            busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_ch2 or negedge rst_n) begin
        if (!rst_n) begin
            move_r        <= 1'b0;
            fusion_rst_n  <= 1'b0;
            busy          <= 1'b1;
            shift_applied <= '0;
            rst_cnt       <= '0;
        end else begin
            move_r        <= move_nxt;
            fusion_rst_n  <= frst_n_nxt;
            busy          <= busy_nxt;
            shift_applied <= applied_nxt;
            rst_cnt       <= rst_cnt_nxt;
        end
    end

endmodule
